// File: rtl/lfsr_pkg.sv
// Shared definitions for the 13-bit LFSR random source and its stream checker.
package lfsr_pkg;
  localparam int              LFSR_W    = 13;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h000F;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;
endpackage

// File: rtl/lfsr_feedback.sv
// LFSR feedback: XOR of the state bits selected by LFSR_TAPS (s[12]^s[3]^s[2]^s[0]).
module lfsr_feedback
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] sr_i,
  output logic              fb_o
);
  logic [LFSR_W-1:0] tapped;

  for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_tap
    assign tapped[gi] = sr_i[gi] & LFSR_TAPS[gi];
  end

  assign fb_o = ^tapped;
endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR stream checker: self-seeds from received bits, verifies, then flywheels its own reference.
// Statistics counters are built only when LFSR_CHK_STATS_EN is defined.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int VERIFY_LEN = 26,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(VERIFY_LEN + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int ERR_W   = $clog2(ERR_THRESH + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(LFSR_W);
  localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(VERIFY_LEN);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0]   ERR_LIMIT  = ERR_W'(ERR_THRESH);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   sr_q, sr_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]    win_err_q, win_err_d;
  logic                err_pulse_q, err_pulse_d;
  logic                exp_bit, mismatch, locked_bit, locked_miss;

  lfsr_feedback u_feedback (
    .sr_i (sr_q),
    .fb_o (exp_bit)
  );

  assign mismatch    = in_bit ^ exp_bit;
  assign locked_bit  = in_valid && (state_q == LOCKED);
  assign locked_miss = locked_bit && mismatch;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          sr_d       = {sr_q[LFSR_W-2:0], in_bit};
          fill_cnt_d = (fill_cnt_q == FILL_FULL) ? fill_cnt_q : fill_cnt_q + FILL_W'(1);
          // An all-zero window is the LFSR lockup value; keep sliding until it clears.
          if (fill_cnt_d == FILL_FULL && sr_d != '0) begin
            state_d     = VERIFY;
            match_cnt_d = '0;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            sr_d        = {sr_q[LFSR_W-2:0], in_bit};
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_d == MATCH_DONE) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            state_d    = HUNT;
            sr_d       = '0;
            fill_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the reference advances on its own prediction, never on the line.
          sr_d        = {sr_q[LFSR_W-2:0], exp_bit};
          err_pulse_d = mismatch;
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = ERR_W'(mismatch);
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_q + ERR_W'(mismatch);
          end
          if (mismatch && win_err_d == ERR_LIMIT) begin
            state_d    = HUNT;
            sr_d       = '0;
            fill_cnt_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

`ifdef LFSR_CHK_STATS_EN
  logic [CNT_W-1:0] err_count_q, bit_count_q;

  // Counters survive loss of lock; only reset or clear_stats zeroes them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
      bit_count_q <= '0;
    end else if (clear_stats) begin
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      if (locked_bit && !(&bit_count_q)) bit_count_q <= bit_count_q + CNT_W'(1);
      if (locked_miss && !(&err_count_q)) err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
`else
  logic unused_stats;
  assign unused_stats = clear_stats ^ locked_bit ^ locked_miss;
  assign err_count    = '0;
  assign bit_count    = '0;
`endif
endmodule
